div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and quotient width; remainder is also WIDTH bits.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 clear  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 A  in  WIDTH  signed dividend.
REQ-006 B  in  WIDTH  signed divisor.
REQ-007 Chigh  out  WIDTH  signed remainder, consumed by ALU high result half.
REQ-008 Clow  out  WIDTH  signed quotient, consumed by ALU low result half.
REQ-009 busy  out  1  high from accepted start until done cycle inclusive.
REQ-010 done  out  1  single-cycle pulse; Chigh/Clow valid from this cycle.
REQ-011 div_by_zero  out  1  status of last completed operation, held until next accepted start.

Function
REQ-012 The block SHALL implement a radix-2 non-restoring division on operand magnitudes, with one partial-remainder add/subtract per clock.
REQ-013 FSM states: IDLE, ITER, FIX, DONE; IDLE->ITER on start with B!=0; IDLE->DONE on start with B==0; ITER->FIX after exactly WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 On accepted start, A and B SHALL be latched; later input changes SHALL not affect the operation.
REQ-015 A start in any state other than IDLE SHALL be ignored, with no effect on the operation in progress.
REQ-016 FIX SHALL perform the final remainder restore (add divisor if partial remainder negative), then apply signs: quotient negative iff A and B signs differ, remainder takes the sign of A.
REQ-017 Latency: done SHALL be high exactly WIDTH+2 clocks after the edge sampling start (34 for WIDTH=32).
REQ-018 Divide by zero: done SHALL be high 1 clock after start, Clow = all ones, Chigh = A, div_by_zero = 1.
REQ-019 Overflow (A = most negative, B = -1): Clow = most negative value (wraps), Chigh = 0, div_by_zero = 0.
REQ-020 Chigh/Clow SHALL hold their last result from done until the done of the next operation; no intermediate values SHALL appear on them.
REQ-021 The internal partial remainder SHALL be WIDTH+1 bits to hold the sign during add/subtract.
REQ-022 A start sampled in the same cycle done is high SHALL be ignored, because the FSM is in DONE, not IDLE.

Reset
REQ-023 On clear low, the FSM SHALL enter IDLE immediately and set Chigh=0, Clow=0, busy=0, done=0, div_by_zero=0, and the iteration counter to 0, regardless of clock.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse; the first start after clear deasserts SHALL proceed normally.

Structure
REQ-025 The shared package alu_pkg SHALL hold the FSM state enum, the 5-bit opcode constants (DIV = 5'b10000, MUL = 5'b01111, ...), and the default WIDTH.
REQ-026 One sub-module, nr_div_step, SHALL be combinational: one add/subtract step (inputs partial remainder, divisor; outputs next remainder, quotient bit); all registers stay in div_unit.
REQ-027 The iteration counter SHALL be clog2(WIDTH)+1 bits wide.

Verification
REQ-028 A=100, B=7, start -> done at clock 34; Clow=14; Chigh=2; div_by_zero=0.
REQ-029 A=-100 (0xFFFFFF9C), B=7 -> Clow=0xFFFFFFF2 (-14); Chigh=0xFFFFFFFE (-2).
REQ-030 A=100, B=0 -> done at clock 1; Clow=0xFFFFFFFF; Chigh=100; div_by_zero=1.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> Clow=0x80000000; Chigh=0; div_by_zero=0.
REQ-032 Start 100/7, then at clock 10 pulse start with A=9, B=3 -> second start ignored; result 14/2 at clock 34.
REQ-033 Start 100/7, assert clear at clock 15 -> outputs 0 immediately; no done; a fresh 50/5 start after release -> Clow=10, Chigh=0 at clock 34.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  alu_pkg
//  Shared ALU definitions: divider FSM state encoding, opcode constants and
//  the default datapath width.
//  Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default operand / result width for the ALU datapath
  localparam int DEFAULT_WIDTH = 32;

  // 5-bit opcode constants
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  // Divider sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/nr_div_step.sv
`default_nettype none
// ============================================================================
//  nr_div_step
//  One radix-2 non-restoring division step (purely combinational): shift the
//  partial remainder left taking in the next dividend bit, then subtract the
//  divisor if the old remainder was non-negative, otherwise add it back.
//  Revision: 1.0 - initial release
// ============================================================================
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvsr_ext;

  // Shift-in plus conditional add/subtract; the quotient bit is set when the
  // new partial remainder stays non-negative.  Dropping the old sign bit in the
  // shift is safe: the true result always lies in the WIDTH+1 bit range.
  always_comb begin
    shifted  = {rem_in[WIDTH-1:0], shift_in};
    dvsr_ext = {1'b0, divisor};
    if (rem_in[WIDTH]) begin
      rem_out = shifted + dvsr_ext;
    end else begin
      rem_out = shifted - dvsr_ext;
    end
    q_bit = ~rem_out[WIDTH];
  end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  div_unit
//  Signed WIDTH-bit sequential divider. Divides operand magnitudes with a
//  radix-2 non-restoring algorithm (one step per clock), restores the final
//  remainder and applies signs. Quotient on Clow, remainder on Chigh.
//  Revision: 1.0 - initial release
// ============================================================================
module div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Chigh,
  output logic [WIDTH-1:0] Clow,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_t state, state_next;

  logic [CNT_W-1:0] iter_cnt;
  logic [WIDTH:0]   prem;        // signed partial remainder
  logic [WIDTH-1:0] quo;         // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr;        // divisor magnitude
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_mag;
  logic             b_zero;
  logic             accept;

  nr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in  (prem),
    .shift_in(quo[WIDTH-1]),
    .divisor (dvsr),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Operand magnitudes, divide-by-zero detect and final remainder restore
  always_comb begin
    a_mag   = A[WIDTH-1] ? (~A + ONE) : A;
    b_mag   = B[WIDTH-1] ? (~B + ONE) : B;
    b_zero  = (B == '0);
    accept  = (state == IDLE) && start;
    rem_mag = prem[WIDTH] ? (prem[WIDTH-1:0] + dvsr) : prem[WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic and status outputs
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = b_zero ? DONE : ITER;
        end
      end
      ITER: begin
        if (iter_cnt == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign fix-up and result registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      iter_cnt    <= '0;
      prem        <= '0;
      quo         <= '0;
      dvsr        <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      Chigh       <= '0;
      Clow        <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        iter_cnt    <= '0;
        prem        <= '0;
        quo         <= a_mag;
        dvsr        <= b_mag;
        neg_quo     <= A[WIDTH-1] ^ B[WIDTH-1];
        neg_rem     <= A[WIDTH-1];
        div_by_zero <= b_zero;
        // Divide by zero completes directly: all-ones quotient, dividend as remainder
        if (b_zero) begin
          Clow  <= '1;
          Chigh <= A;
        end
      end else if (state == ITER) begin
        prem     <= step_rem;
        quo      <= {quo[WIDTH-2:0], step_q};
        iter_cnt <= iter_cnt + CNT_W'(1);
      end else if (state == FIX) begin
        Clow  <= neg_quo ? (~quo + ONE) : quo;
        Chigh <= neg_rem ? (~rem_mag + ONE) : rem_mag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  tb_div_unit
//  Scoreboard bench for div_unit: stimulus pushes hand-computed expected
//  results, a monitor pops and compares whenever done is presented.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           start_edge;
  } exp_t;

  logic         clock;
  logic         clear;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Chigh;
  logic [W-1:0] Clow;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .A          (A),
    .B          (B),
    .Chigh      (Chigh),
    .Clow       (Clow),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head
  always @(negedge clock) begin
    if (clear && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", Clow, e.q);
        chk("remainder", Chigh, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", cyc - e.start_edge + 1, e.lat);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Issue one operation: push expectation, pulse start, scramble inputs afterwards
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    @(negedge clock);
    A = a;
    B = b;
    start = 1'b1;
    e.q = q; e.r = r; e.dz = dz;
    e.lat = (b == '0) ? 1 : W + 2;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Wait (bounded) for done; leaves the caller on the done negedge
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    issue(a, b, q, r, dz);
    wait_done();
    @(negedge clock);
  endtask

  initial begin
    clear = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clock);
    chk("reset_chigh", Chigh, '0);
    chk("reset_clow", Clow, '0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dz", {31'd0, div_by_zero}, 32'd0);
    clear = 1'b1;
    @(negedge clock);

    // Basic signed divisions
    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0);
    run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    run(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0);
    run(32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1'b0);
    run(32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0);

    // Divide by zero, status held afterwards
    run(32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1);
    repeat (3) @(negedge clock);
    chk("dz_held", {31'd0, div_by_zero}, 32'd1);
    chk("dz_result_held", Chigh, 32'd100);

    // Overflow wraps
    run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);

    // Start while busy is ignored; outputs hold previous result mid-operation
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (7) @(negedge clock);
    A = 32'd9;
    B = 32'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("hold_clow_mid_op", Clow, 32'h80000000);
    chk("hold_chigh_mid_op", Chigh, 32'd0);
    chk("busy_mid_op", {31'd0, busy}, 32'd1);
    wait_done();

    // Start sampled during the done cycle is ignored
    A = 32'd9;
    B = 32'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);

    // Reset mid-operation aborts with outputs cleared immediately
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    void'(sb.pop_back());
    repeat (12) @(negedge clock);
    #2;
    clear = 1'b0;
    #1;
    chk("abort_chigh", Chigh, '0);
    chk("abort_clow", Clow, '0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_no_busy", {31'd0, busy}, 32'd0);
    run(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
